// File: rtl/data_mem_responder_if.sv
// MEM-stage data port bundle between the pipeline (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int unsigned WB_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(WB_DEPTH) + 1;

    logic [31:0]      mem_addr;
    logic [31:0]      mem_write_data;
    logic             mem_wr;
    logic             mem_rd;
    logic             mem_sb;
    logic             mem_sh;
    logic             mem_lb;
    logic             mem_lh;
    logic [31:0]      mem_read_data;
    logic [CNT_W-1:0] wb_count;
    logic             wb_full;
    logic             wb_empty;
    logic             misalign;
    logic [31:0]      misalign_addr;

    modport master (
        output mem_addr, mem_write_data, mem_wr, mem_rd, mem_sb, mem_sh, mem_lb, mem_lh,
        input  mem_read_data, wb_count, wb_full, wb_empty, misalign, misalign_addr
    );

    modport slave (
        input  mem_addr, mem_write_data, mem_wr, mem_rd, mem_sb, mem_sh, mem_lb, mem_lh,
        output mem_read_data, wb_count, wb_full, wb_empty, misalign, misalign_addr
    );
endinterface

// File: rtl/data_mem_responder.sv
// Big-endian data memory with a posted, merging write buffer and zero-latency load forwarding.
// Optional MISALIGN_TRAP_EN: sticky misaligned-access flag with first-address capture.
module data_mem_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WB_DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(WB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem     [DEPTH];
    logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
    logic [31:0]       wb_data [WB_DEPTH];
    logic [3:0]        wb_mask [WB_DEPTH];

    logic [PTR_W-1:0]  rd_ptr, wr_ptr, young;
    logic [CNT_W-1:0]  count;
    logic              full, empty;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       st_data, young_merged, drain_data, ld_word, ld_sized;
    logic [3:0]        st_mask, drain_mask;
    logic              store_en, merge, push, drain, merge_oldest;

    assign word_addr = bus.mem_addr[ADDR_W+1:2];
    assign full      = (count == CNT_W'(WB_DEPTH));
    assign empty     = (count == '0);
    assign young     = wr_ptr - PTR_W'(1);

    // Store data is replicated across lanes; the mask picks the live ones.
    always_comb begin
        st_mask = 4'b1111;
        st_data = bus.mem_write_data;
        if (bus.mem_sb) begin
            st_mask = 4'b1000 >> bus.mem_addr[1:0];
            st_data = {4{bus.mem_write_data[7:0]}};
        end else if (bus.mem_sh) begin
            st_mask = bus.mem_addr[1] ? 4'b0011 : 4'b1100;
            st_data = {2{bus.mem_write_data[15:0]}};
        end
    end

    always_comb begin
        young_merged = wb_data[young];
        for (int i = 0; i < 4; i++) begin
            if (st_mask[i]) young_merged[8*i +: 8] = st_data[8*i +: 8];
        end
    end

    assign store_en     = reset && bus.mem_wr;
    assign merge        = store_en && !empty && (wb_addr[young] == word_addr);
    assign push         = store_en && !merge;
    assign drain        = reset && !empty && (!bus.mem_rd || full);
    // A merge into the single entry being drained must reach the array in the same write.
    assign merge_oldest = merge && (count == CNT_W'(1));
    assign drain_data   = merge_oldest ? young_merged : wb_data[rd_ptr];
    assign drain_mask   = merge_oldest ? (wb_mask[rd_ptr] | st_mask) : wb_mask[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (drain) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (merge) begin
            wb_data[young] <= young_merged;
            wb_mask[young] <= wb_mask[young] | st_mask;
        end
        if (push) begin
            wb_addr[wr_ptr] <= word_addr;
            wb_data[wr_ptr] <= st_data;
            wb_mask[wr_ptr] <= st_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            for (int i = 0; i < 4; i++) begin
                if (drain_mask[i]) mem[wb_addr[rd_ptr]][8*i +: 8] <= drain_data[8*i +: 8];
            end
        end
    end

    // Overlay buffered stores oldest to youngest so the youngest byte wins.
    always_comb begin : fwd_blk
        logic [PTR_W-1:0] idx;
        idx     = rd_ptr;
        ld_word = mem[word_addr];
        for (int e = 0; e < WB_DEPTH; e++) begin
            idx = rd_ptr + PTR_W'(e);
            if ((CNT_W'(e) < count) && (wb_addr[idx] == word_addr)) begin
                for (int i = 0; i < 4; i++) begin
                    if (wb_mask[idx][i]) ld_word[8*i +: 8] = wb_data[idx][8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ld_sized = ld_word;
        if (bus.mem_lb) begin
            case (bus.mem_addr[1:0])
                2'd0:    ld_sized = {24'b0, ld_word[31:24]};
                2'd1:    ld_sized = {24'b0, ld_word[23:16]};
                2'd2:    ld_sized = {24'b0, ld_word[15:8]};
                default: ld_sized = {24'b0, ld_word[7:0]};
            endcase
        end else if (bus.mem_lh) begin
            ld_sized = {16'b0, (bus.mem_addr[1] ? ld_word[15:0] : ld_word[31:16])};
        end
    end

    assign bus.mem_read_data = !reset ? 32'b0 : (bus.mem_rd ? ld_sized : ld_word);
    assign bus.wb_count      = count;
    assign bus.wb_full       = full;
    assign bus.wb_empty      = empty;

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
    logic        mis_flag;
    logic [31:0] mis_addr;
    logic        st_mis, ld_mis;

    assign st_mis = bus.mem_wr && !bus.mem_sb &&
                    (bus.mem_sh ? bus.mem_addr[0] : (bus.mem_addr[1:0] != 2'b00));
    assign ld_mis = bus.mem_rd && !bus.mem_lb &&
                    (bus.mem_lh ? bus.mem_addr[0] : (bus.mem_addr[1:0] != 2'b00));

    // First misaligned address is held until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mis_flag <= 1'b0;
            mis_addr <= '0;
        end else if ((st_mis || ld_mis) && !mis_flag) begin
            mis_flag <= 1'b1;
            mis_addr <= bus.mem_addr;
        end
    end

    assign bus.misalign      = mis_flag;
    assign bus.misalign_addr = mis_addr;
`else
    assign bus.misalign      = 1'b0;
    assign bus.misalign_addr = 32'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed cases plus randomized traffic against a byte-level memory model.
module tb_data_mem_responder;
    localparam int unsigned WB_DEPTH = 4;
    localparam int unsigned ADDR_W   = 10;

    logic clk = 1'b0;
    logic reset;

    data_mem_responder_if #(.WB_DEPTH(WB_DEPTH)) bus ();
    data_mem_responder #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int w; logic [31:0] d; logic [3:0] m; } ent_t;
    typedef struct {
        bit          chk_rd;
        logic [31:0] rd;
        int          cnt;
        bit          mis;
        logic [31:0] mis_addr;
    } exp_t;

    ent_t        wbq[$];
    exp_t        sbq[$];
    logic [31:0] arr   [int];
    logic [3:0]  arr_m [int];
    bit          m_mis;
    logic [31:0] m_mis_addr;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] overlay(input logic [31:0] base, input logic [31:0] d, input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) base[8*i +: 8] = d[8*i +: 8];
        return base;
    endfunction

    function automatic logic [31:0] view(input int w);
        logic [31:0] v;
        v = arr.exists(w) ? arr[w] : 32'h0;
        foreach (wbq[k]) if (wbq[k].w == w) v = overlay(v, wbq[k].d, wbq[k].m);
        return v;
    endfunction

    function automatic bit known(input int w);
        logic [3:0] m;
        m = arr_m.exists(w) ? arr_m[w] : 4'h0;
        foreach (wbq[k]) if (wbq[k].w == w) m = m | wbq[k].m;
        return m == 4'hF;
    endfunction

    function automatic bit misaligned(input bit wr, input bit rd, input bit sb, input bit sh,
                                      input bit lb, input bit lh, input logic [31:0] a);
        bit low_nz;
        low_nz = (a[1:0] != 2'b00);
        return (wr && !sb && (sh ? a[0] : low_nz)) || (rd && !lb && (lh ? a[0] : low_nz));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    // One cycle: drive, predict what the DUT shows this cycle, then advance the model past the edge.
    task automatic drive(input bit rst, input bit wr, input bit rd, input bit sb, input bit sh,
                         input bit lb, input bit lh, input logic [31:0] a, input logic [31:0] data);
        exp_t        e;
        int          w, k;
        logic [31:0] v, d;
        logic [3:0]  m;
        bit          drn, do_push;
        reset = rst;
        bus.mem_wr = wr; bus.mem_rd = rd; bus.mem_sb = sb; bus.mem_sh = sh;
        bus.mem_lb = lb; bus.mem_lh = lh; bus.mem_addr = a; bus.mem_write_data = data;
        w = int'(a[ADDR_W+1:2]);
        v = view(w);
        e.chk_rd = !rst || (rd && known(w));
        if (!rst)          e.rd = 32'h0;
        else if (rd && lb) e.rd = (v >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
        else if (rd && lh) e.rd = (v >> (16 * (1 - int'(a[1])))) & 32'hFFFF;
        else               e.rd = v;
        e.cnt = wbq.size();
`ifdef MISALIGN_TRAP_EN
        e.mis = m_mis; e.mis_addr = m_mis_addr;
`else
        e.mis = 1'b0; e.mis_addr = 32'h0;
`endif
        sbq.push_back(e);
        @(posedge clk);
        if (!rst) begin
            wbq.delete();
            m_mis = 1'b0; m_mis_addr = 32'h0;
        end else begin
            drn = (wbq.size() > 0) && (!rd || wbq.size() == WB_DEPTH);
            do_push = 1'b0;
            d = 32'h0; m = 4'h0;
            if (wr) begin
                if (sb) begin
                    k = int'(a[1:0]);
                    d = {24'h0, data[7:0]} << (8 * (3 - k));
                    m = 4'b0001 << (3 - k);
                end else if (sh) begin
                    k = int'(a[1]);
                    d = {16'h0, data[15:0]} << (16 * (1 - k));
                    m = 4'b0011 << (2 * (1 - k));
                end else begin
                    d = data; m = 4'hF;
                end
                k = wbq.size() - 1;
                if (wbq.size() > 0 && wbq[k].w == w) begin
                    wbq[k].d = overlay(wbq[k].d, d, m);
                    wbq[k].m = wbq[k].m | m;
                end else do_push = 1'b1;
            end
            if (drn) begin
                ent_t o;
                o = wbq.pop_front();
                arr[o.w]   = overlay(arr.exists(o.w) ? arr[o.w] : 32'h0, o.d, o.m);
                arr_m[o.w] = (arr_m.exists(o.w) ? arr_m[o.w] : 4'h0) | o.m;
            end
            if (do_push) wbq.push_back('{w, d, m});
            if (!m_mis && misaligned(wr, rd, sb, sh, lb, lh, a)) begin
                m_mis = 1'b1; m_mis_addr = a;
            end
        end
        #1;
    endtask

    // sz: 0 byte, 1 half, 2 word
    task automatic st(input int sz, input logic [31:0] a, input logic [31:0] data, input bit rd = 1'b0);
        drive(1'b1, 1'b1, rd, sz == 0, sz == 1, 1'b0, 1'b0, a, data);
    endtask
    task automatic ld(input int sz, input logic [31:0] a);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, sz == 0, sz == 1, a, 32'h0);
    endtask
    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.chk_rd) check("mem_read_data", bus.mem_read_data, e.rd);
                check("wb_count", 32'(bus.wb_count), 32'(e.cnt));
                check("wb_full", 32'(bus.wb_full), 32'(e.cnt == WB_DEPTH));
                check("wb_empty", 32'(bus.wb_empty), 32'(e.cnt == 0));
                check("misalign", 32'(bus.misalign), 32'(e.mis));
                check("misalign_addr", bus.misalign_addr, e.mis_addr);
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus.mem_wr = 1'b1; bus.mem_rd = 1'b0; bus.mem_sb = 1'b0; bus.mem_sh = 1'b0;
        bus.mem_lb = 1'b0; bus.mem_lh = 1'b0; bus.mem_addr = 32'h40; bus.mem_write_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h5555_5555);

        st(2, 32'h40, 32'hDEAD_BEEF);
        idle();
        ld(2, 32'h40);

        // Reset discards a pending store; the array keeps its contents.
        st(2, 32'h40, 32'h0102_0304);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h7777_7777);
        ld(2, 32'h40);

        st(2, 32'h80, 32'h1122_3344);
        st(0, 32'h82, 32'h0000_00AA);
        ld(0, 32'h82);
        ld(2, 32'h80);

        for (int i = 0; i < 5; i++) st(2, 32'hC0 + 32'(4 * i), $urandom, 1'b1);
        for (int i = 0; i < 5; i++) ld(2, 32'hC0 + 32'(4 * i));
        repeat (5) idle();

        st(2, 32'h100, 32'hCAFE_F00D);
        ld(1, 32'h102);
        ld(1, 32'h100);
        idle();

        ld(1, 32'h203);
        idle();
        ld(2, 32'h305);
        idle();

        for (int i = 0; i < 8; i++) st(2, 32'h400 + 32'(4 * i), $urandom);
        repeat (6) idle();
        for (int n = 0; n < 400; n++) begin
            int          r, sz;
            logic [31:0] a;
            r  = int'($urandom_range(99));
            sz = int'($urandom_range(2));
            a  = 32'h400 + ($urandom_range(7) << 2) + $urandom_range(3);
            if (r < 3)       drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a, 32'h0);
            else if (r < 48) st(sz, a, $urandom);
            else if (r < 88) ld(sz, a);
            else             idle();
        end
        repeat (6) idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
